// File: rtl/fpu_mul_wb_stage.sv
// ---------------------------------------------------------------------------
// fpu_mul_wb_stage
//
// Registered write-back stage behind the single-cycle FP32 multiplier.
// Results enter through a valid/ready handshake. Each result is turned into
// its canonical IEEE-754 encoding before it is stored in a small FIFO. The
// FIFO then feeds a register-file write port that is allowed to stall. The
// per-result exception flags are folded into sticky RISC-V style fflags when
// the consumer pops that result.
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_flush             discard all queued entries (sticky flags untouched)
//   i_in_valid          multiplier result valid
//   o_in_ready          stage can accept a result (count < DEPTH)
//   i_tag               destination register tag
//   i_S                 raw multiplier result
//   i_overflow          multiplier overflow / infinity flag
//   i_underflow         multiplier underflow flag
//   i_zero              multiplier zero-result flag
//   i_NaN               multiplier invalid / NaN flag
//   o_out_valid         head entry valid
//   i_out_ready         consumer accepts the head entry
//   o_tag, o_S          head entry tag and canonical result
//   o_fflags            sticky {NV,DZ,OF,UF,NX}
//   i_fflags_clr        clear the sticky flags
//   o_count             FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fpu_mul_wb_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [TAG_W-1:0]         i_tag,
    input  logic [31:0]              i_S,
    input  logic                     i_overflow,
    input  logic                     i_underflow,
    input  logic                     i_zero,
    input  logic                     i_NaN,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [TAG_W-1:0]         o_tag,
    output logic [31:0]              o_S,
    output logic [4:0]               o_fflags,
    input  logic                     i_fflags_clr,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      s;
        logic [4:0]       flags;   // {NV,DZ,OF,UF,NX}
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       fflags_q, fflags_d;

    entry_t push_entry;
    entry_t head;
    logic   push;
    logic   pop;
    logic   out_valid;
    logic   of_flag;
    logic   uf_flag;

    // Ready looks only at occupancy, so a full FIFO refuses a push even in a
    // cycle where the consumer pops; this keeps i_out_ready off o_in_ready.
    assign o_in_ready = (count_q < FULL_CNT);
    assign out_valid  = (count_q != '0);
    assign push       = i_in_valid & o_in_ready;
    assign pop        = out_valid & i_out_ready;

    // Canonicalise at push time so the FIFO only ever holds final encodings.
    // NaN takes priority over overflow, which takes priority over zero.
    assign of_flag = i_overflow  & ~i_NaN;
    assign uf_flag = i_underflow & ~i_NaN;

    always_comb begin
        // NOTE: every field gets a value on every path, so no latch can form.
        push_entry.tag   = i_tag;
        push_entry.flags = {i_NaN, 1'b0, of_flag, uf_flag, of_flag | uf_flag};
        if (i_NaN)
            push_entry.s = 32'h7FC0_0000;
        else if (i_overflow)
            push_entry.s = {i_S[31], 8'hFF, 23'h0};
        else if (i_zero)
            push_entry.s = {i_S[31], 31'h0};
        else
            push_entry.s = i_S;
    end

    // NOTE: the storage array has no reset. Stale contents can never be seen,
    // because the outputs below are forced to zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push && !i_flush)
            mem_q[wr_ptr_q] <= push_entry;
    end

    assign head = mem_q[rd_ptr_q];

    // Next-state logic. Flush wins over any push or pop in the same cycle.
    // The sticky-flag clear still applies during a flush.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fflags_d = i_fflags_clr ? 5'b0 : fflags_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);   // DEPTH is a power of two: wraps naturally
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                fflags_d = fflags_d | head.flags;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    // Reset clears count_q asynchronously, so these fall with i_rst.
    assign o_out_valid = out_valid;
    assign o_S         = out_valid ? head.s   : 32'h0;
    assign o_tag       = out_valid ? head.tag : '0;
    assign o_fflags    = fflags_q;
    assign o_count     = count_q;

endmodule

// File: doc/fpu_mul_wb_stage.md
Name: fpu_mul_wb_stage

Overview:
Registered write-back stage directly downstream of the FP32 multiplier datapath. It captures the multiplier's combinational result and status flags under a valid/ready handshake and buffers them in a small FIFO. It canonicalises special results (NaN, overflow, zero) into IEEE-754 encodings and maintains RISC-V-style sticky exception flags until software clears them. It decouples the single-cycle multiplier from a register-file write port that may stall.

Parameters:
DEPTH, 2, FIFO entries; power of two, ≥2
TAG_W, 5, destination-register tag width

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-high reset
i_flush  in  1  synchronous FIFO discard; does not touch flags
i_in_valid  in  1  multiplier result valid
o_in_ready  out  1  stage can accept; =(count<DEPTH)
i_tag  in  TAG_W  destination tag travelling with result
i_S  in  32  raw multiplier result; bit31 = result sign
i_overflow  in  1  multiplier overflow/infinity flag
i_underflow  in  1  multiplier underflow flag
i_zero  in  1  multiplier zero-result flag
i_NaN  in  1  multiplier invalid/NaN flag
o_out_valid  out  1  head entry valid
i_out_ready  in  1  consumer accepts head
o_tag  out  TAG_W  head tag
o_S  out  32  head canonical result
o_fflags  out  5  sticky {NV,DZ,OF,UF,NX}
i_fflags_clr  in  1  clear sticky flags
o_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async assert, sync release): count=0, read/write pointers=0, o_out_valid=0, o_tag=0, o_S=0, o_fflags=0, o_in_ready=1.
- Push = i_in_valid & o_in_ready; pop = o_out_valid & i_out_ready.
- o_in_ready depends on count only, never on i_out_ready (no combinational path from input to output). When full, push is blocked even if a pop happens in the same cycle.
- Latency: a push into an empty FIFO is visible at o_out_valid/o_S/o_tag the next cycle. There is no same-cycle bypass.
- Output data comes from the head entry. It is held stable while o_out_valid=1 and i_out_ready=0.
- Canonicalisation is applied at push and stored in the FIFO. Priority order:
  - i_NaN → 32'h7FC00000
  - else i_overflow → {i_S[31],8'hFF,23'h0}
  - else i_zero → {i_S[31],31'h0}
  - else i_S unchanged
- Each entry also stores 5 flag bits:
  - NV = i_NaN
  - DZ = 0
  - OF = i_overflow & ~i_NaN
  - UF = i_underflow & ~i_NaN
  - NX = OF | UF
- Sticky flags accumulate at pop, not push: o_fflags_next = (i_fflags_clr ? 0 : o_fflags) | (pop ? head_flags : 0). A same-cycle clear and pop leaves exactly the popped flags.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- i_flush: next cycle count=0, pointers=0, o_out_valid=0. Any push or pop in the flush cycle is discarded, so a popped entry's flags are not accumulated. o_fflags is still cleared if i_fflags_clr is asserted.
- Reset mid-transfer: all entries are lost immediately and o_out_valid falls asynchronously.
- o_count equals the number of valid entries, 0..DEPTH.

Test Plan:
- Basic: push i_S=32'h40C00000 (6.0), tag 3, flags 0, i_out_ready=1 → next cycle o_out_valid=1, o_S=32'h40C00000, o_tag=3; popped following cycle; o_fflags stays 0.
- Canonical: push i_NaN=1,i_S=32'hFFFFFFFF; then i_overflow=1,i_S=32'h80123456; then i_zero=1,i_S=32'h80000001 → outputs 32'h7FC00000, 32'hFF800000, 32'h80000000 in order; after all pops o_fflags=5'b10101.
- Backpressure: i_out_ready=0, push 3 results → first two accepted, o_in_ready=0 after second, o_count=2; third held by source. Raise i_out_ready → drains in order, then third accepted.
- Simultaneous: count=1, push+pop same cycle → o_count stays 1, order preserved; count=DEPTH with pop → push refused that cycle.
- Flags: sticky OF set; assert i_fflags_clr same cycle as popping a UF entry → o_fflags=5'b00011.
- Flush/reset: 2 entries queued, i_flush → o_out_valid=0, o_count=0 next cycle, o_fflags unchanged. Assert i_rst mid-stream → all outputs 0 without waiting for a clock edge.
